// File: rtl/data_memory.sv
// Multi-cycle RV32 data memory: latches a load/store request, stalls the core for
// LATENCY cycles, then commits the access and presents an extended result for one DONE cycle.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8,
  parameter int LATENCY     = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       counter;
  logic [31:0]            mem [DEPTH_WORDS];

  logic [ADDR_BITS+1:0]   addr_p0;
  logic [31:0]            wdata_p0;
  logic [2:0]             func3_p0;
  logic                   write_p0;

  logic                   request;
  logic                   commit;
  logic [ADDR_BITS-1:0]   idx_p0;
  logic [1:0]             lane_p0;
  logic                   unused_addr;

  assign request     = MEM_READ | MEM_WRITE;
  assign commit      = (state == BUSY) && (counter == '0);
  assign idx_p0      = addr_p0[ADDR_BITS+1:2];
  assign lane_p0     = addr_p0[1:0];
  assign unused_addr = ^MEM_ADDRESS[31:ADDR_BITS+2];

  assign BUSYWAIT = !RESET && ((state == BUSY) || ((state == IDLE) && request));

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b   = word[{lane, 3'b000} +: 8];
    h   = lane[1] ? word[31:16] : word[15:0];
    ext = '0;
    case (f3)
      3'b000:  ext = 32'(b);
      3'b001:  ext = 32'(h);
      3'b010:  ext = word;
      3'b100:  ext = {24'h0, b};
      3'b101:  ext = {16'h0, h};
      default: ext = '0;
    endcase
    return ext;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] w;
    w = old_word;
    case (f3)
      3'b000: w[{lane, 3'b000} +: 8] = wdata[7:0];
      3'b001: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      3'b010: w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Halfword codes flag an odd address; word codes flag any non-zero lane.
  function automatic logic misaligned_flag(input logic [2:0] f3,
                                           input logic [1:0] lane,
                                           input logic       is_write);
    logic m;
    m = 1'b0;
    case (f3)
      3'b001:  m = lane[0];
      3'b101:  m = lane[0] && !is_write;
      3'b010:  m = (lane != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Stage p0: request capture, taken only on an accepted IDLE request
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && request) begin
      addr_p0  <= MEM_ADDRESS[ADDR_BITS+1:0];
      wdata_p0 <= MEM_WRITE_DATA;
      func3_p0 <= FUNC3;
      write_p0 <= MEM_WRITE;
    end
  end

  // Commit: control FSM, memory array and registered results
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      counter    <= '0;
      READ_DATA  <= '0;
      MISALIGNED <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            counter <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (commit) begin
            MISALIGNED <= misaligned_flag(func3_p0, lane_p0, write_p0);
            if (write_p0) begin
              if (func3_p0 inside {3'b000, 3'b001, 3'b010})
                mem[idx_p0] <= store_merge(mem[idx_p0], wdata_p0, lane_p0, func3_p0);
            end else begin
              READ_DATA <= load_extend(mem[idx_p0], lane_p0, func3_p0);
            end
            state <= DONE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares when BUSYWAIT falls at a DONE cycle.
module tb_data_memory;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [2:0]  FUNC3;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_bw  = 1'b0;

  data_memory #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(5)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA), .FUNC3(FUNC3),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: a completion is the first non-reset cycle with BUSYWAIT low after it was high.
  always @(negedge CLK) begin
    if (!RESET && prev_bw && !BUSYWAIT) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rd"}, READ_DATA, e.rd);
        check({e.name, "_mis"}, {31'h0, MISALIGNED}, {31'h0, e.mis});
      end
    end
    prev_bw = BUSYWAIT;
  end

  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rd,
                        input logic exp_mis);
    exp_t e;
    int   cnt;
    @(posedge CLK);
    #1;
    MEM_READ       = rd;
    MEM_WRITE      = wr;
    MEM_ADDRESS    = addr;
    MEM_WRITE_DATA = wdata;
    FUNC3          = f3;
    e.rd   = exp_rd;
    e.mis  = exp_mis;
    e.name = name;
    exp_q.push_back(e);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) cnt++;
      else break;
    end
    check({name, "_busy_cycles"}, cnt, 32'd6);
  endtask

  task automatic idle_inputs();
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    FUNC3          = 3'b000;
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    MEM_READ = 1'b1;
    #1;
    check("reset_busywait", {31'h0, BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle_inputs();
    check("reset_read_data", READ_DATA, 32'h0);
    check("reset_misaligned", {31'h0, MISALIGNED}, 32'd0);
    check("idle_busywait", {31'h0, BUSYWAIT}, 32'd0);

    access("lw_zero",   1, 0, 32'h20, 32'h0,        3'b010, 32'h00000000, 0);
    access("sw_10",     0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h00000000, 0);
    access("lw_10a",    1, 0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0);
    access("sb_11",     0, 1, 32'h11, 32'hFFFFFF80, 3'b000, 32'hDEADBEEF, 0);
    access("lw_10b",    1, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD80EF, 0);
    access("lb_11",     1, 0, 32'h11, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    access("lbu_11",    1, 0, 32'h11, 32'h0,        3'b100, 32'h00000080, 0);
    access("sh_12",     0, 1, 32'h12, 32'h12348001, 3'b001, 32'h00000080, 0);
    access("lh_12",     1, 0, 32'h12, 32'h0,        3'b001, 32'hFFFF8001, 0);
    access("lhu_12",    1, 0, 32'h12, 32'h0,        3'b101, 32'h00008001, 0);
    access("lw_10c",    1, 0, 32'h10, 32'h0,        3'b010, 32'h800180EF, 0);
    access("lh_13",     1, 0, 32'h13, 32'h0,        3'b001, 32'hFFFF8001, 1);
    access("lb_10",     1, 0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 0);
    access("lw_13",     1, 0, 32'h13, 32'h0,        3'b010, 32'h800180EF, 1);
    access("lw_10d",    1, 0, 32'h10, 32'h0,        3'b010, 32'h800180EF, 0);
    access("ld_bad",    1, 0, 32'h10, 32'h0,        3'b011, 32'h00000000, 0);

    // Store aborted by reset asserted during its third BUSY cycle.
    @(posedge CLK);
    #1;
    MEM_WRITE      = 1'b1;
    MEM_ADDRESS    = 32'h20;
    MEM_WRITE_DATA = 32'hCAFEF00D;
    FUNC3          = 3'b010;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    idle_inputs();
    MEM_WRITE = 1'b1;
    #1;
    check("abort_busywait", {31'h0, BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle_inputs();
    check("abort_read_data", READ_DATA, 32'h0);
    access("lw_20_after_abort", 1, 0, 32'h20, 32'h0, 3'b010, 32'h00000000, 0);

    access("sw_400",    0, 1, 32'h400, 32'h12345678, 3'b010, 32'h00000000, 0);
    access("lw_000",    1, 0, 32'h000, 32'h0,        3'b010, 32'h12345678, 0);
    access("rw_both",   1, 1, 32'h008, 32'hA5A5A5A5, 3'b010, 32'h12345678, 0);
    access("st_bad",    0, 1, 32'h008, 32'h00000000, 3'b011, 32'h12345678, 0);
    access("lw_008",    1, 0, 32'h008, 32'h0,        3'b010, 32'hA5A5A5A5, 0);
    access("sw_mis",    0, 1, 32'h00A, 32'h0F0F0F0F, 3'b010, 32'hA5A5A5A5, 1);
    access("lw_008b",   1, 0, 32'h008, 32'h0,        3'b010, 32'h0F0F0F0F, 0);

    @(posedge CLK);
    #1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("hold_read_data", READ_DATA, 32'h0F0F0F0F);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
